// File: rtl/stb_data_sync.sv
// stb_data_sync: synchronises an asynchronous strobe, detects the selected edge(s)
// and queues the data word present at each qualifying edge in a FWFT FIFO.
module stb_data_sync #(
    parameter int N      = 8,
    parameter int STAGES = 2,
    parameter int DEPTH  = 4,
    parameter int EDGE   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       stb,
    input  logic [N-1:0]               data_in,
    output logic [N-1:0]               data_out,
    output logic                       valid,
    input  logic                       ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STAGES + 2);
    localparam logic [SW-1:0] SETTLE = SW'(STAGES + 1);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);

    logic [STAGES-1:0] sync_q;
    logic              s_d_q;
    logic [SW-1:0]     settle_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              overflow_q;
    logic [N-1:0]      mem_q [DEPTH];

    logic s;
    logic rise;
    logic fall;
    logic ev;
    logic settled;
    logic full;
    logic push;
    logic pop;
    logic wr_en;

    assign s       = sync_q[STAGES-1];
    assign rise    = s & ~s_d_q;
    assign fall    = ~s & s_d_q;
    assign settled = (settle_q == '0);
    assign full    = (count_q == FULL);
    assign valid   = (count_q != '0);
    assign push    = ev & ena & settled;
    assign pop     = valid & ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en   = push & (~full | pop);

    always_comb begin
        case (EDGE)
            1:       ev = fall;
            2:       ev = rise | fall;
            default: ev = rise;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            s_d_q      <= 1'b0;
            settle_q   <= SETTLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], stb};
            s_d_q   <= s;
            count_q <= count_d;
            if (!settled) begin
                settle_q <= settle_q - SW'(1);
            end
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage is never reset; stale entries are hidden by the valid mask below.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = valid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_stb_data_sync.sv
// Bench for stb_data_sync: rising, falling and both-edge instances share one stimulus
// stream; a queue model built from the sampled strobe history predicts every output.
`timescale 1ns/1ps
module tb_stb_data_sync;
    localparam int N      = 8;
    localparam int STAGES = 2;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int HMAX   = 8192;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b1;
    logic         stb = 1'b0;
    logic         ready = 1'b0;
    logic [N-1:0] data_in = '0;
    logic [N-1:0] dout [3];
    logic         valid [3];
    logic [CW-1:0] cnt [3];
    logic         ovf [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stb_data_sync #(.N(N), .STAGES(STAGES), .DEPTH(DEPTH), .EDGE(0)) u_rise (
        .clk(clk), .rst(rst), .ena(ena), .stb(stb), .data_in(data_in),
        .data_out(dout[0]), .valid(valid[0]), .ready(ready), .count(cnt[0]), .overflow(ovf[0]));
    stb_data_sync #(.N(N), .STAGES(STAGES), .DEPTH(DEPTH), .EDGE(1)) u_fall (
        .clk(clk), .rst(rst), .ena(ena), .stb(stb), .data_in(data_in),
        .data_out(dout[1]), .valid(valid[1]), .ready(ready), .count(cnt[1]), .overflow(ovf[1]));
    stb_data_sync #(.N(N), .STAGES(STAGES), .DEPTH(DEPTH), .EDGE(2)) u_both (
        .clk(clk), .rst(rst), .ena(ena), .stb(stb), .data_in(data_in),
        .data_out(dout[2]), .valid(valid[2]), .ready(ready), .count(cnt[2]), .overflow(ovf[2]));

    // Reference model: an event at edge k is a strobe level change between the samples
    // taken STAGES+1 and STAGES edges earlier, eligible once STAGES+2 edges past reset.
    int           k = 0;
    int           last_rst = -1000;
    bit           sh [HMAX];
    logic [N-1:0] mq [3][$];
    bit           movf [3];

    always @(posedge clk) begin
        bit a, b, ev, pop;
        k++;
        sh[k % HMAX] = stb;
        if (rst) begin
            last_rst = k;
            for (int m = 0; m < 3; m++) begin
                mq[m].delete();
                movf[m] = 1'b0;
            end
        end else begin
            a = sh[(k - STAGES - 1) % HMAX];
            b = sh[(k - STAGES) % HMAX];
            for (int m = 0; m < 3; m++) begin
                case (m)
                    0:       ev = !a && b;
                    1:       ev = a && !b;
                    default: ev = (a != b);
                endcase
                pop = (mq[m].size() > 0) && ready;
                if (pop) void'(mq[m].pop_front());
                if (ev && ena && (k >= last_rst + STAGES + 2)) begin
                    if (mq[m].size() < DEPTH) mq[m].push_back(data_in);
                    else movf[m] = 1'b1;
                end
            end
        end
    end

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        stb = 1'b0; ena = 1'b1; ready = 1'b0; rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(STAGES + 2);
    endtask

    task automatic rise_fall(input logic [N-1:0] d);
        stb = 1'b1; data_in = d;
        ticks(4);
        stb = 1'b0;
        ticks(4);
    endtask

    task automatic test_reset();
        stb = 1'b0; ena = 1'b1; ready = 1'b0; data_in = '0; rst = 1'b1;
        ticks(3);
        rst = 1'b0;
        ticks(1);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (valid[m] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got %0b exp 0", m, valid[m]); end
            checks++;
            if (cnt[m] !== '0) begin errors++; $display("FAIL reset_count[%0d] got %0d exp 0", m, cnt[m]); end
            checks++;
            if (dout[m] !== '0) begin errors++; $display("FAIL reset_dout[%0d] got %0h exp 0", m, dout[m]); end
            checks++;
            if (ovf[m] !== 1'b0) begin errors++; $display("FAIL reset_ovf[%0d] got %0b exp 0", m, ovf[m]); end
        end
        ticks(STAGES + 2);
        data_in = 8'hA5; stb = 1'b1;
        ticks(2);
        checks++;
        if (valid[0] !== 1'b0) begin errors++; $display("FAIL latency_early got valid %0b exp 0", valid[0]); end
        ticks(1);
        checks++;
        if (valid[0] !== 1'b1) begin errors++; $display("FAIL latency_valid got %0b exp 1", valid[0]); end
        checks++;
        if (dout[0] !== 8'hA5) begin errors++; $display("FAIL latency_dout got %0h exp a5", dout[0]); end
        ready = 1'b1;
        ticks(1);
        ready = 1'b0;
        checks++;
        if (valid[0] !== 1'b0) begin errors++; $display("FAIL pop_valid got %0b exp 0", valid[0]); end
        checks++;
        if (dout[0] !== '0) begin errors++; $display("FAIL pop_dout got %0h exp 0", dout[0]); end
    endtask

    task automatic test_both_edges();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            stb = ~stb; data_in = N'(i + 1);
            ticks(4);
        end
        checks++;
        if (cnt[2] !== CW'(4)) begin errors++; $display("FAIL both_count got %0d exp 4", cnt[2]); end
        checks++;
        if (ovf[2] !== 1'b0) begin errors++; $display("FAIL both_ovf got %0b exp 0", ovf[2]); end
        checks++;
        if (cnt[0] !== CW'(2)) begin errors++; $display("FAIL rise_only_count got %0d exp 2", cnt[0]); end
        checks++;
        if (cnt[1] !== CW'(2)) begin errors++; $display("FAIL fall_only_count got %0d exp 2", cnt[1]); end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout[2] !== N'(i + 1)) begin errors++; $display("FAIL both_drain[%0d] got %0h exp %0h", i, dout[2], i + 1); end
            ticks(1);
        end
        ready = 1'b0;
        checks++;
        if (valid[2] !== 1'b0) begin errors++; $display("FAIL both_empty got %0b exp 0", valid[2]); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) rise_fall(N'(8'h10 + i));
        checks++;
        if (cnt[0] !== CW'(4)) begin errors++; $display("FAIL ovf_count got %0d exp 4", cnt[0]); end
        checks++;
        if (ovf[0] !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", ovf[0]); end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout[0] !== N'(8'h10 + i)) begin errors++; $display("FAIL ovf_drain[%0d] got %0h exp %0h", i, dout[0], 8'h10 + i); end
            ticks(1);
        end
        ready = 1'b0;
        checks++;
        if (valid[0] !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0b exp 0", valid[0]); end
        checks++;
        if (ovf[0] !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", ovf[0]); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 4; i++) rise_fall(N'(8'h20 + i));
        data_in = 8'h24; stb = 1'b1;
        ticks(2);
        ready = 1'b1;
        ticks(1);
        ready = 1'b0;
        checks++;
        if (cnt[0] !== CW'(4)) begin errors++; $display("FAIL fullpop_count got %0d exp 4", cnt[0]); end
        checks++;
        if (ovf[0] !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %0b exp 0", ovf[0]); end
        ticks(2);
        stb = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout[0] !== N'(8'h21 + i)) begin errors++; $display("FAIL fullpop_drain[%0d] got %0h exp %0h", i, dout[0], 8'h21 + i); end
            ticks(1);
        end
        ready = 1'b0;
    endtask

    task automatic test_stb_through_reset();
        stb = 1'b1; ena = 1'b1; ready = 1'b0; rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(6);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (cnt[m] !== '0) begin errors++; $display("FAIL held_stb_count[%0d] got %0d exp 0", m, cnt[m]); end
        end
        data_in = 8'h5A; stb = 1'b0;
        ticks(4);
        checks++;
        if (cnt[1] !== CW'(1)) begin errors++; $display("FAIL fall_count got %0d exp 1", cnt[1]); end
        checks++;
        if (dout[1] !== 8'h5A) begin errors++; $display("FAIL fall_dout got %0h exp 5a", dout[1]); end
        checks++;
        if (cnt[0] !== '0) begin errors++; $display("FAIL fall_rise_inst got %0d exp 0", cnt[0]); end
    endtask

    task automatic test_ena_and_midreset();
        do_reset();
        ena = 1'b0; data_in = 8'h33; stb = 1'b1;
        ticks(4);
        ena = 1'b1;
        ticks(4);
        checks++;
        if (cnt[0] !== '0) begin errors++; $display("FAIL ena_discard got %0d exp 0", cnt[0]); end
        stb = 1'b0;
        ticks(4);
        for (int i = 0; i < 5; i++) rise_fall(N'(8'h40 + i));
        ready = 1'b1;
        ticks(1);
        ready = 1'b0;
        checks++;
        if (cnt[0] !== CW'(3)) begin errors++; $display("FAIL midq_count got %0d exp 3", cnt[0]); end
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
        checks++;
        if (cnt[0] !== '0) begin errors++; $display("FAIL midrst_count got %0d exp 0", cnt[0]); end
        checks++;
        if (valid[0] !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b exp 0", valid[0]); end
        checks++;
        if (ovf[0] !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %0b exp 0", ovf[0]); end
    endtask

    task automatic test_random();
        int hold;
        logic [N-1:0] exp_d;
        do_reset();
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                stb = ~stb;
                data_in = N'($urandom);
                hold = $urandom_range(STAGES + 1, STAGES + 5);
            end
            hold--;
            ena   = ($urandom_range(0, 9) != 0);
            ready = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            ticks(1);
            for (int m = 0; m < 3; m++) begin
                exp_d = (mq[m].size() > 0) ? mq[m][0] : '0;
                checks++;
                if (cnt[m] !== CW'(mq[m].size())) begin errors++; $display("FAIL rnd_count[%0d] cyc %0d got %0d exp %0d", m, c, cnt[m], mq[m].size()); end
                checks++;
                if (valid[m] !== (mq[m].size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] cyc %0d got %0b exp %0b", m, c, valid[m], mq[m].size() > 0); end
                checks++;
                if (dout[m] !== exp_d) begin errors++; $display("FAIL rnd_dout[%0d] cyc %0d got %0h exp %0h", m, c, dout[m], exp_d); end
                checks++;
                if (ovf[m] !== movf[m]) begin errors++; $display("FAIL rnd_ovf[%0d] cyc %0d got %0b exp %0b", m, c, ovf[m], movf[m]); end
            end
        end
        rst = 1'b0; ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_both_edges();
        test_overflow();
        test_full_pop();
        test_stb_through_reset();
        test_ena_and_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule
